// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath widths, load funct3 encodings and the
// writeback-stage state encoding.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // Load size/sign encodings carried in funct3.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_IDLE     = 2'd0,
    WB_WAIT_MEM = 2'd1,
    WB_WRITE    = 2'd2
  } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Combinational load data aligner/extender: picks the addressed byte or
// halfword out of a raw memory word and sign- or zero-extends it.
// Undefined funct3 values pass the full word through, as for LW.
module load_extend
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and extension; every path assigns ext_data.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase

    // Halfword lane uses only addr_lo[1]; misaligned bit 0 is ignored.
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  ext_data = {24'b0, byte_sel};
      F3_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  ext_data = {16'b0, half_sel};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// RV32I writeback stage: retires one instruction per handshake, waits for
// the data-memory response on loads, and drives the register-file write
// port (wb_data / wb_rd / regwrite) with registered outputs.
// Optional build macro WB_RETIRE_CNT_EN adds a 64-bit retire counter port.
module writeback_stage #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_regwrite,
  input  logic              in_mem_to_reg,
  input  logic [2:0]        in_funct3,
  input  logic [1:0]        in_addr_lo,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [XLEN-1:0]   wb_data,
  output logic [REG_AW-1:0] wb_rd,
  output logic              regwrite,
  output logic              stall
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]       retire_cnt
`endif
);

  import riscv_pkg::*;

  wb_state_e         state_q, state_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic              regwrite_q, regwrite_d;

  // Context of the outstanding load, held while waiting for memory.
  logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
  logic              ld_we_q, ld_we_d;
  logic [2:0]        ld_funct3_q, ld_funct3_d;
  logic [1:0]        ld_addr_q, ld_addr_d;

  logic [31:0]       ld_ext;
  logic              accept;

  load_extend u_load_extend (
    .funct3   (ld_funct3_q),
    .addr_lo  (ld_addr_q),
    .rdata    (mem_rdata[31:0]),
    .ext_data (ld_ext)
  );

  // Ready depends only on state, and is held low throughout reset.
  assign in_ready = rst_n & (state_q != WB_WAIT_MEM);
  assign stall    = ~in_ready;
  assign accept   = in_valid & in_ready;

  // Next-state and next-output logic for the retire FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    regwrite_d  = 1'b0;
    ld_rd_d     = ld_rd_q;
    ld_we_d     = ld_we_q;
    ld_funct3_d = ld_funct3_q;
    ld_addr_d   = ld_addr_q;

    case (state_q)
      WB_IDLE, WB_WRITE: begin
        if (accept) begin
          if (in_mem_to_reg) begin
            state_d     = WB_WAIT_MEM;
            ld_rd_d     = in_rd;
            ld_we_d     = in_regwrite;
            ld_funct3_d = in_funct3;
            ld_addr_d   = in_addr_lo;
          end else begin
            state_d    = WB_WRITE;
            wb_data_d  = in_alu_result;
            wb_rd_d    = in_rd;
            regwrite_d = in_regwrite & (in_rd != '0);
          end
        end else begin
          state_d = WB_IDLE;
        end
      end

      WB_WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d    = WB_WRITE;
          wb_data_d  = XLEN'(ld_ext);
          wb_rd_d    = ld_rd_q;
          regwrite_d = ld_we_q & (ld_rd_q != '0);
        end
      end

      default: state_d = WB_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the load context is cleared too so an abandoned load leaves no
      // stale destination behind; it is never consumed outside WB_WAIT_MEM.
      state_q     <= WB_IDLE;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      regwrite_q  <= 1'b0;
      ld_rd_q     <= '0;
      ld_we_q     <= 1'b0;
      ld_funct3_q <= F3_LW;
      ld_addr_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q     <= state_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      regwrite_q  <= regwrite_d;
      ld_rd_q     <= ld_rd_d;
      ld_we_q     <= ld_we_d;
      ld_funct3_q <= ld_funct3_d;
      ld_addr_q   <= ld_addr_d;
    end
  end

  assign wb_data  = wb_data_q;
  assign wb_rd    = wb_rd_q;
  assign regwrite = regwrite_q;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q, retire_cnt_d;

  // Count every commit cycle, including rd=0 commits; wraps naturally.
  always_comb begin
    retire_cnt_d = retire_cnt_q + 64'(state_q == WB_WRITE);
  end

  // Retire counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) retire_cnt_q <= '0;
    else        retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule
